// File: rtl/putc_arbiter.sv
// putc_arbiter: round-robin sharing of the single dev_io putc port among N
// character producers, with optional per-owner locking across characters
// and a lock-timeout that frees the port when a locked owner goes quiet.
//
// Handshake: a requester raises req_push[i] with a stable char and holds it
// until req_done[i] pulses; the arbiter raises putc_push (level) toward
// dev_io and holds putc_char/grant constant until putc_push_done pulses.
// During the cycle req_done is high every req_push is ignored (guard cycle),
// because the requester may still be showing the character just sent.
module putc_arbiter #(
  parameter int N            = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_push,
  input  logic [8*N-1:0] req_char,
  input  logic [N-1:0]   req_lock,
  output logic [N-1:0]   req_done,
  output logic [N-1:0]   grant,
  output logic           lock_timeout,
  output logic           putc_push,
  output logic [7:0]     putc_char,
  input  logic           putc_push_done,
  output logic [1:0]     dbg_state
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_owner_q, last_owner_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic          to_q, to_d;
  logic          push_q, push_d;
  logic [7:0]    char_q, char_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          guard;
  logic          found;
  logic [IW-1:0] win;

  assign guard = |done_q;

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    win   = last_owner_q;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_owner_q) + k) % N;
      if (!found && req_push[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  // Next-state and output logic for the IDLE / PUSH / HOLD controller.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    done_d       = '0;
    to_d         = 1'b0;
    push_d       = push_q;
    char_d       = char_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found && !guard) begin
          owner_d      = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          char_d       = req_char[{win, 3'b000} +: 8];
          push_d       = 1'b1;
          state_d      = S_PUSH;
        end
      end
      S_PUSH: begin
        if (putc_push_done) begin
          push_d = 1'b0;
          done_d = grant_q;
          if (req_lock[owner_q]) begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            last_owner_d = owner_q;
            grant_d      = '0;
            state_d      = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (req_push[owner_q] && !guard) begin
          char_d  = req_char[{owner_q, 3'b000} +: 8];
          push_d  = 1'b1;
          state_d = S_PUSH;
        end else if (!req_lock[owner_q]) begin
          last_owner_d = owner_q;
          grant_d      = '0;
          state_d      = S_IDLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          to_d         = 1'b1;
          last_owner_d = owner_q;
          grant_d      = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        push_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset makes requester 0 the first round-robin winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(N - 1);
      grant_q      <= '0;
      done_q       <= '0;
      to_q         <= 1'b0;
      push_q       <= 1'b0;
      char_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      to_q         <= to_d;
      push_q       <= push_d;
      char_q       <= char_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_done     = done_q;
  assign grant        = grant_q;
  assign lock_timeout = to_q;
  assign putc_push    = push_q;
  assign putc_char    = char_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_putc_arbiter.sv
// Bench for putc_arbiter: requester queues, a dev_io sink model with a
// configurable acceptance delay, and a queue-level ordering model.
module tb_putc_arbiter;

  localparam int N   = 2;
  localparam int TMO = 8;

  typedef logic [8:0] ent_t;      // {lock, char}
  typedef ent_t ent_q_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_push;
  logic [15:0]  req_char;
  logic [1:0]   req_lock;
  logic [1:0]   req_done;
  logic [1:0]   grant;
  logic         lock_timeout;
  logic         putc_push;
  logic [7:0]   putc_char;
  logic         putc_push_done;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  ent_t       q0[$];
  ent_t       q1[$];
  logic [7:0] push_log[$];
  logic [7:0] exp_q[$];
  int         sink_delay = 0;
  int         wait_cnt   = 0;
  logic [1:0] lock_force = 2'b00;
  int         done0 = 0, done1 = 0, to_cnt = 0, rise_cnt = 0;
  logic       push_prev = 1'b0;

  putc_arbiter #(.N(N), .LOCK_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_push       (req_push),
    .req_char       (req_char),
    .req_lock       (req_lock),
    .req_done       (req_done),
    .grant          (grant),
    .lock_timeout   (lock_timeout),
    .putc_push      (putc_push),
    .putc_char      (putc_char),
    .putc_push_done (putc_push_done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    lock_force = 2'b00;
    sink_delay = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_log.delete();
    done0 = 0; done1 = 0; to_cnt = 0; rise_cnt = 0;
    @(posedge clk);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (push_log.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #2;
  endtask

  // ---------------- requester drivers ----------------
  // Each requester presents the front of its queue; on req_done it advances,
  // keeping its previous lock level for that one cycle so a locked message
  // stays owned until the next character is pushed.
  initial begin
    req_push = '0;
    req_char = '0;
    req_lock = '0;
    forever begin
      @(posedge clk);
      #1;
      if (req_done[0] && q0.size() > 0) q0.delete(0);
      if (req_done[1] && q1.size() > 0) q1.delete(1 - 1);
      if (q0.size() > 0) begin
        req_push[0]   = 1'b1;
        req_char[7:0] = q0[0][7:0];
        if (!req_done[0]) req_lock[0] = q0[0][8] | lock_force[0];
      end else begin
        req_push[0] = 1'b0;
        if (!req_done[0]) req_lock[0] = lock_force[0];
      end
      if (q1.size() > 0) begin
        req_push[1]    = 1'b1;
        req_char[15:8] = q1[0][7:0];
        if (!req_done[1]) req_lock[1] = q1[0][8] | lock_force[1];
      end else begin
        req_push[1] = 1'b0;
        if (!req_done[1]) req_lock[1] = lock_force[1];
      end
    end
  end

  // ---------------- dev_io sink model ----------------
  initial begin
    putc_push_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (putc_push_done) begin
        putc_push_done = 1'b0;
      end else if (putc_push && rst) begin
        if (wait_cnt >= sink_delay) begin
          putc_push_done = 1'b1;
          wait_cnt       = 0;
          push_log.push_back(putc_char);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- event monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (req_done[0]) done0++;
      if (req_done[1]) done1++;
      if (lock_timeout) to_cnt++;
      if (putc_push && !push_prev) rise_cnt++;
      push_prev = putc_push;
    end
  end

  // ---------------- reference ordering model ----------------
  // With every requester continuously pending, the output is: take turns
  // starting after the previous owner; an owner keeps going while the char
  // just sent was locked and it still has more to send.
  task automatic model_order(input ent_q_t a, input ent_q_t b);
    int   last;
    int   own;
    ent_t e;
    bit   more;
    last = N - 1;
    exp_q.delete();
    while (a.size() + b.size() > 0) begin
      own = (last + 1) % N;
      if ((own == 0 && a.size() == 0) || (own == 1 && b.size() == 0)) own = 1 - own;
      do begin
        if (own == 0) e = a.pop_front();
        else          e = b.pop_front();
        exp_q.push_back(e[7:0]);
        more = e[8] && ((own == 0) ? (a.size() > 0) : (b.size() > 0));
      end while (more);
      last = own;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++;
    if ({grant, req_done, lock_timeout, putc_push, putc_char} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {grant, req_done, lock_timeout, putc_push, putc_char});
    end
    apply_reset();
    total++;
    if ({grant, req_done, lock_timeout, putc_push} !== 6'd0) begin
      bad++;
      $display("FAIL reset_idle: got %h want 0", {grant, req_done, lock_timeout, putc_push});
    end
  endtask

  task automatic test_single_send();
    apply_reset();
    #2;
    q0.push_back({1'b0, 8'h41});
    @(posedge clk);
    #2;
    total++;
    if (putc_push !== 1'b0) begin
      bad++;
      $display("FAIL single_early: putc_push got %b want 0", putc_push);
    end
    @(posedge clk);
    #2;
    total++;
    if ({putc_push, putc_char, grant} !== {1'b1, 8'h41, 2'b01}) begin
      bad++;
      $display("FAIL single_push: got push=%b char=%h grant=%b want 1 41 01", putc_push, putc_char, grant);
    end
    wait_log(1, 20);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (push_log.size() !== 1 || push_log[0] !== 8'h41) begin
      bad++;
      $display("FAIL single_log: got size=%0d want 1 char 41", push_log.size());
    end
    total++;
    if ({done0, done1, rise_cnt} !== {32'd1, 32'd0, 32'd1}) begin
      bad++;
      $display("FAIL single_counts: got done0=%0d done1=%0d pushes=%0d want 1 0 1", done0, done1, rise_cnt);
    end
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("FAIL single_grant: got %b want 00", grant);
    end
  endtask

  task automatic test_round_robin();
    ent_t a[$];
    ent_t b[$];
    apply_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      a.push_back({1'b0, 8'h30});
      b.push_back({1'b0, 8'h31});
    end
    q0 = a;
    q1 = b;
    model_order(a, b);
    wait_log(8, 200);
    total++;
    if (push_log.size() !== 8) begin
      bad++;
      $display("FAIL rr_count: got %0d want 8", push_log.size());
    end
    for (int i = 0; i < 8 && i < push_log.size(); i++) begin
      total++;
      if (push_log[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rr_order[%0d]: got %h want %h", i, push_log[i], exp_q[i]);
      end
    end
    total++;
    if (push_log.size() > 0 && push_log[0] !== 8'h30) begin
      bad++;
      $display("FAIL rr_first: got %h want 30", push_log[0]);
    end
  endtask

  task automatic test_lock();
    int c;
    int grant_bad;
    apply_reset();
    #2;
    q1.push_back({1'b1, 8'h4F});
    q1.push_back({1'b1, 8'h4B});
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (grant !== 2'b10 && c < 20);
    #1;
    q0.push_back({1'b0, 8'h21});
    total++;
    if (grant !== 2'b10) begin
      bad++;
      $display("FAIL lock_grant_first: got %b want 10", grant);
    end
    grant_bad = 0;
    c = 0;
    while (push_log.size() < 2 && c < 200) begin
      if (grant !== 2'b10) grant_bad++;
      @(posedge clk);
      #1;
      c++;
    end
    total++;
    if (grant_bad !== 0) begin
      bad++;
      $display("FAIL lock_grant_held: got %0d cycles off owner want 0", grant_bad);
    end
    wait_log(3, 100);
    total++;
    if (push_log.size() !== 3) begin
      bad++;
      $display("FAIL lock_count: got %0d want 3", push_log.size());
    end else begin
      total++;
      if ({push_log[0], push_log[1], push_log[2]} !== {8'h4F, 8'h4B, 8'h21}) begin
        bad++;
        $display("FAIL lock_order: got %h %h %h want 4f 4b 21", push_log[0], push_log[1], push_log[2]);
      end
    end
  endtask

  task automatic test_timeout();
    int c;
    int n;
    apply_reset();
    #2;
    lock_force = 2'b01;
    q0.push_back({1'b1, 8'h55});
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (req_done[0] !== 1'b1 && c < 30);
    #1;
    q1.push_back({1'b0, 8'h66});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (lock_timeout !== 1'b1 && n < 50);
    total++;
    if (n !== TMO) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TMO);
    end
    @(posedge clk);
    #2;
    total++;
    if ({putc_push, putc_char, grant} !== {1'b1, 8'h66, 2'b10}) begin
      bad++;
      $display("FAIL timeout_next: got push=%b char=%h grant=%b want 1 66 10", putc_push, putc_char, grant);
    end
    lock_force = 2'b00;
    wait_log(2, 50);
    total++;
    if (push_log.size() !== 2 || to_cnt !== 1) begin
      bad++;
      $display("FAIL timeout_summary: got chars=%0d pulses=%0d want 2 1", push_log.size(), to_cnt);
    end
  endtask

  task automatic test_slow_sink();
    int         c;
    int         unstable;
    logic [7:0] ch;
    logic [1:0] gr;
    apply_reset();
    sink_delay = 50;
    #2;
    q0.push_back({1'b0, 8'h77});
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (putc_push !== 1'b1 && c < 20);
    ch = putc_char;
    gr = grant;
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (putc_push !== 1'b1 || putc_char !== ch || grant !== gr || req_done !== 2'b00) unstable++;
    end
    total++;
    if (unstable !== 0 || ch !== 8'h77) begin
      bad++;
      $display("FAIL slow_stable: got %0d unstable cycles char=%h want 0 77", unstable, ch);
    end
    wait_log(1, 20);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (done0 !== 1 || push_log.size() !== 1) begin
      bad++;
      $display("FAIL slow_done: got done0=%0d chars=%0d want 1 1", done0, push_log.size());
    end
  endtask

  task automatic test_reset_mid_push();
    int c;
    apply_reset();
    #2;
    q0.push_back({1'b0, 8'h50});
    wait_log(1, 20);
    sink_delay = 100;
    q0.push_back({1'b0, 8'h51});
    q1.push_back({1'b0, 8'h61});
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (putc_push !== 1'b1 && c < 20);
    total++;
    if ({putc_char, grant} !== {8'h61, 2'b10}) begin
      bad++;
      $display("FAIL rmp_pre: got char=%h grant=%b want 61 10", putc_char, grant);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({grant, req_done, lock_timeout, putc_push, putc_char} !== 14'd0) begin
      bad++;
      $display("FAIL rmp_async: got %h want 0", {grant, req_done, lock_timeout, putc_push, putc_char});
    end
    repeat (3) @(posedge clk);
    sink_delay = 0;
    push_log.delete();
    @(negedge clk);
    rst = 1'b1;
    wait_log(2, 60);
    total++;
    if (push_log.size() !== 2) begin
      bad++;
      $display("FAIL rmp_count: got %0d want 2", push_log.size());
    end else begin
      total++;
      if ({push_log[0], push_log[1]} !== {8'h51, 8'h61}) begin
        bad++;
        $display("FAIL rmp_order: got %h %h want 51 61", push_log[0], push_log[1]);
      end
    end
    total++;
    if (done1 !== 1) begin
      bad++;
      $display("FAIL rmp_done1: got %0d want 1", done1);
    end
  endtask

  task automatic test_random();
    ent_t a[$];
    ent_t b[$];
    int   n0;
    int   n1;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      sink_delay = $urandom_range(0, 3);
      #2;
      a.delete();
      b.delete();
      n0 = $urandom_range(1, 6);
      n1 = $urandom_range(0, 6);
      for (int i = 0; i < n0; i++) a.push_back(ent_t'({$urandom_range(0, 1), $urandom_range(0, 255)}));
      for (int i = 0; i < n1; i++) b.push_back(ent_t'({$urandom_range(0, 1), $urandom_range(0, 255)}));
      q0 = a;
      q1 = b;
      model_order(a, b);
      wait_log(exp_q.size(), 1500);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (push_log.size() !== exp_q.size()) begin
        bad++;
        $display("FAIL rand%0d_count: got %0d want %0d", r, push_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
        total++;
        if (push_log[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand%0d_order[%0d]: got %h want %h", r, i, push_log[i], exp_q[i]);
        end
      end
      total++;
      if (done0 !== n0 || done1 !== n1 || to_cnt !== 0) begin
        bad++;
        $display("FAIL rand%0d_counts: got done=%0d/%0d to=%0d want %0d/%0d 0", r, done0, done1, to_cnt, n0, n1);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_single_send();
    test_round_robin();
    test_lock();
    test_timeout();
    test_slow_sink();
    test_reset_mid_push();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
